// File: rtl/spine_xbar_router.sv
// Spine crossbar: per-input FIFOs, head-of-line route decode and drop, per-output round-robin into one register.
// Accept-to-out_valid latency is 2 edges; in_ready falls only when that input's FIFO is full, outputs hold while stalled.
module spine_xbar_router #(
  parameter logic [3:0] GROUP_ID   = 4'b0001,
  parameter int         NUM_LEAF   = 4,
  parameter int         NUM_GROUP  = 7,
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  localparam int NUM_PORTS = NUM_LEAF + NUM_GROUP,
  localparam int LID_W     = ($clog2(NUM_LEAF) > 1) ? $clog2(NUM_LEAF) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DWIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [NUM_PORTS*DWIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS-1:0]        fifo_full,
  output logic [15:0]                 drop_count
);
  localparam int          PW       = $clog2(NUM_PORTS);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DWIDTH-1:0]    head_dat   [NUM_PORTS];
  logic [PW-1:0]        dest       [NUM_PORTS];
  logic [PW-1:0]        gnt_sel    [NUM_PORTS];
  logic [PW-1:0]        last_grant [NUM_PORTS];
  logic [DWIDTH-1:0]    out_dat_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_empty, pop, route_ok, drop, gnt, out_vld_q;
  logic [16:0]          drop_sum;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [AW:0]       cnt;
    logic              push;
    logic [3:0]        dgrp;
    logic [LID_W-1:0]  dleaf;
    int                dst;
    logic              ok;

    assign fifo_full[p]  = (cnt == FULL_CNT);
    assign fifo_empty[p] = (cnt == '0);
    assign in_ready[p]   = !fifo_full[p];
    assign push          = in_valid[p] && !fifo_full[p];
    assign head_dat[p]   = mem[rptr];

    always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_data[p*DWIDTH +: DWIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push)   wptr <= wptr + 1'b1;
        if (pop[p]) rptr <= rptr + 1'b1;
        if (push && !pop[p])      cnt <= cnt + 1'b1;
        else if (!push && pop[p]) cnt <= cnt - 1'b1;
      end
    end

    // Remote groups are numbered without our own group, hence the skip above GROUP_ID.
    assign dgrp  = head_dat[p][DWIDTH-1 -: 4];
    assign dleaf = head_dat[p][DWIDTH-5 -: LID_W];
    always_comb begin
      ok  = 1'b1;
      dst = 0;
      if (dgrp == GROUP_ID) begin
        dst = int'(dleaf);
        ok  = int'(dleaf) < NUM_LEAF;
      end else if (int'(dgrp) <= NUM_GROUP) begin
        dst = NUM_LEAF + ((dgrp < GROUP_ID) ? int'(dgrp) : int'(dgrp) - 1);
      end else begin
        ok = 1'b0;
      end
      if (dst == p) ok = 1'b0;
    end

    assign route_ok[p] = !fifo_empty[p] && ok;
    assign drop[p]     = !fifo_empty[p] && !ok;
    assign dest[p]     = PW'(dst);
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic          found;
    logic [PW-1:0] sel;
    int            idx;

    always_comb begin
      found = 1'b0;
      sel   = last_grant[o];
      idx   = 0;
      if (!out_vld_q[o] || out_ready[o]) begin
        for (int k = 1; k <= NUM_PORTS; k++) begin
          idx = (int'(last_grant[o]) + k) % NUM_PORTS;
          if (!found && route_ok[idx] && dest[idx] == PW'(o)) begin
            found = 1'b1;
            sel   = PW'(idx);
          end
        end
      end
    end

    assign gnt[o]     = found;
    assign gnt_sel[o] = sel;
    assign out_data[o*DWIDTH +: DWIDTH] = out_dat_q[o];
  end

  assign out_valid = out_vld_q;

  // Each input requests a single output, so an input can never collect two grants.
  always_comb begin
    pop = drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (gnt[o]) pop[gnt_sel[o]] = 1'b1;
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 17'(drop[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_dat_q[o]  <= '0;
        last_grant[o] <= PW'(NUM_PORTS - 1);
      end
      out_vld_q  <= '0;
      drop_count <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (gnt[o]) begin
          out_dat_q[o]  <= head_dat[gnt_sel[o]];
          out_vld_q[o]  <= 1'b1;
          last_grant[o] <= gnt_sel[o];
        end else if (out_ready[o]) begin
          out_vld_q[o] <= 1'b0;
        end
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
endmodule

// File: tb/tb_spine_xbar_router.sv
// Directed bench for spine_xbar_router: a route model fills per-output queues at input accept,
// a negedge monitor pops and compares every output handshake.
module tb_spine_xbar_router;
  localparam int NL = 4;
  localparam int NG = 7;
  localparam int NP = NL + NG;
  localparam int DW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [NP*DW-1:0] in_data;
  logic [NP*DW-1:0] out_data;
  logic [NP-1:0]  in_valid, in_ready, out_valid, out_ready, fifo_full;
  logic [15:0]    drop_count;

  int             vectors = 0;
  int             miscompares = 0;
  int             exp_drops = 0;
  int             accepted [NP];
  logic [DW-1:0]  exp_q [NP][$];
  bit             mon_en = 1'b0;

  always #5 clk = ~clk;

  spine_xbar_router #(
    .GROUP_ID(4'b0001), .NUM_LEAF(NL), .NUM_GROUP(NG), .DWIDTH(DW), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_full(fifo_full), .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference routing for GROUP_ID=1: -1 means the flit must be dropped.
  function automatic int route(input int p, input logic [DW-1:0] f);
    int g, l, d;
    g = int'(f[15:12]);
    l = int'(f[11:10]);
    if (g == 1)       d = (l < NL) ? l : -1;
    else if (g <= NG) d = NL + ((g < 1) ? g : g - 1);
    else              d = -1;
    if (d == p) d = -1;
    return d;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int o = 0; o < NP; o++) s += exp_q[o].size();
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [DW-1:0] f);
    in_valid[p] = 1'b1;
    in_data[p*DW +: DW] = f;
  endtask

  task automatic commit();
    logic [DW-1:0] f;
    int d;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      if (in_valid[p] && in_ready[p]) begin
        f = in_data[p*DW +: DW];
        d = route(p, f);
        accepted[p]++;
        if (d < 0) begin
          if (exp_drops < 65535) exp_drops++;
        end else begin
          exp_q[d].push_back(f);
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (pending() != 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check(tag, pending(), 0);
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (mon_en) begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          if (exp_q[o].size() == 0) begin
            check($sformatf("extra_out%0d", o), 32'(exp_q[o].size()), 1);
          end else begin
            e = exp_q[o].pop_front();
            check($sformatf("out%0d_data", o), out_data[o*DW +: DW], e);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [NP-1:0] mask;
    int n_acc;
    int n;

    for (int p = 0; p < NP; p++) accepted[p] = 0;
    reset     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data[31:0], 0);
    check("rst_in_ready", in_ready, 11'h7FF);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_drop_count", drop_count, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    mon_en = 1'b1;

    // Three inputs contend for leaf 2; fresh priority starts at port 0.
    drive(0, 16'h1801);
    drive(1, 16'h1802);
    drive(3, 16'h1803);
    commit();
    check("cont_e0_vld", out_valid, 0);
    tick();
    check("cont_1_vld", out_valid, 11'h004);
    check("cont_1_dat", out_data[2*DW +: DW], 16'h1801);
    tick();
    check("cont_2_dat", out_data[2*DW +: DW], 16'h1802);
    tick();
    check("cont_3_dat", out_data[2*DW +: DW], 16'h1803);
    tick();
    check("cont_idle", out_valid, 0);
    drain("cont_drain");

    // Single local route and its two-edge latency.
    drive(0, 16'h1A55);
    commit();
    check("lat_e0_vld", out_valid, 0);
    tick();
    check("lat_e1_vld", out_valid, 11'h004);
    check("lat_e1_dat", out_data[2*DW +: DW], 16'h1A55);
    drain("single_drain");

    // Remote groups below/above GROUP_ID, highest group, group port back to a leaf.
    drive(1, 16'h5000);
    drive(8, 16'h1400);
    drive(0, 16'h7000);
    commit();
    drive(1, 16'h0000);
    commit();
    drain("route_drain");

    // Two disjoint back-to-back streams keep both outputs busy every cycle.
    mask = '0;
    mask[1] = 1'b1;
    mask[8] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 16'h1400 + 16'(k));
      drive(3, 16'h5000 + 16'(k));
      commit();
      if (k > 0) check($sformatf("tput_%0d", k), out_valid & mask, mask);
    end
    tick();
    check("tput_last", out_valid & mask, mask);
    drain("tput_drain");

    // Backpressure on leaf 2 while port 0 streams ten flits.
    out_ready[2] = 1'b0;
    n_acc = accepted[0];
    for (int k = 0; k < 10; k++) begin
      drive(0, 16'h1800 + 16'(k));
      commit();
    end
    check("bp_accepted", accepted[0] - n_acc, 9);
    check("bp_full", fifo_full[0], 1);
    check("bp_in_ready", in_ready[0], 0);
    tick();
    tick();
    check("bp_hold_vld", out_valid[2], 1);
    check("bp_hold_dat", out_data[2*DW +: DW], 16'h1800);
    out_ready[2] = 1'b1;
    drain("bp_drain");

    // Out-of-range group, then a U-turn.
    drive(0, 16'h9000);
    commit();
    drive(2, 16'h1800);
    commit();
    repeat (3) tick();
    check("drop_no_out", out_valid, 0);
    check("drop_count2", drop_count, exp_drops);

    // Flood invalid flits on every port until the counter must saturate.
    n = 0;
    while (exp_drops < 65535 && n < 8000) begin
      for (int p = 0; p < NP; p++) drive(p, 16'hF000);
      commit();
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      for (int p = 0; p < NP; p++) drive(p, 16'hF000);
      commit();
    end
    repeat (3) tick();
    check("drop_sat", drop_count, 16'hFFFF);
    check("drop_sat_no_out", out_valid, 0);

    // Asynchronous reset with flits queued, then a clean restart.
    out_ready[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h1800 + 16'(k));
      commit();
    end
    check("rst_pre_vld", out_valid[2], 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data[2*DW +: DW], 0);
    check("arst_in_ready", in_ready, 11'h7FF);
    check("arst_fifo_full", fifo_full, 0);
    check("arst_drop_count", drop_count, 0);
    for (int o = 0; o < NP; o++) exp_q[o].delete();
    exp_drops = 0;
    @(negedge clk);
    reset = 1'b1;
    out_ready = '1;
    tick();
    check("rst_resume_idle", out_valid, 0);
    drive(0, 16'h1A55);
    commit();
    check("rst_lat_e0", out_valid, 0);
    tick();
    check("rst_lat_e1", out_valid, 11'h004);
    check("rst_lat_dat", out_data[2*DW +: DW], 16'h1A55);
    drain("rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
